// File: rtl/score_counter.sv
// rtl/score_counter.sv - multi-digit BCD score counter with high score and seven-segment outputs
module score_counter #(
  parameter int NUM_DIGITS = 3,
  parameter int SATURATE   = 0,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    add,
  input  logic                    show_hi,
  output logic [7*NUM_DIGITS-1:0] display,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] hi_bcd,
  output logic                    carry_out,
  output logic                    overflow,
  output logic                    new_best
);

  logic [4*NUM_DIGITS-1:0] score;
  logic [4*NUM_DIGITS-1:0] hi;
  logic [4*NUM_DIGITS-1:0] score_inc;
  logic [4*NUM_DIGITS-1:0] src;
  logic                    start_q;
  logic                    ovf;
  logic                    best;
  logic                    all_nines;
  logic                    ripple;
  logic                    upper_zero;
  logic [3:0]              dig;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Ripple a +1 through the digits; a stray non-BCD digit is forced to 0 and absorbs the carry.
  always_comb begin
    score_inc = score;
    ripple    = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (score[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (ripple) begin
        if (score[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else if (score[4*i +: 4] > 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
          ripple = 1'b0;
        end else begin
          score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
          ripple = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score   <= '0;
      hi      <= '0;
      ovf     <= 1'b0;
      best    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= start;
      best    <= 1'b0;
      // Capture uses the pre-clear score, since score is cleared on this same edge.
      if (start_q && !start && (score > hi)) begin
        hi   <= score;
        best <= 1'b1;
      end
      if (!start) begin
        score <= '0;
        ovf   <= 1'b0;
      end else if (add) begin
        if (all_nines) begin
          ovf <= 1'b1;
          if (SATURATE == 0) score <= '0;
        end else begin
          score <= score_inc;
        end
      end
    end
  end

  // Scan from the most significant digit so blanking stops at the first non-zero digit.
  always_comb begin
    display    = '1;
    src        = show_hi ? hi : score;
    upper_zero = 1'b1;
    dig        = 4'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dig        = src[4*i +: 4];
      upper_zero = upper_zero & (dig == 4'd0);
      if ((BLANK_LZ != 0) && (i > 0) && upper_zero) display[7*i +: 7] = 7'b1111111;
      else display[7*i +: 7] = seg7(dig);
    end
  end

  assign score_bcd = score;
  assign hi_bcd    = hi;
  assign overflow  = ovf;
  assign new_best  = best;
  assign carry_out = start & add & all_nines;

endmodule
